// File: rtl/seq_mult_radix.sv
// Radix-2^R sequential multiplier for signed/unsigned operands, with optional early exit.
// Latency K+1 cycles after accept (K = 1..ceil(DW/R) RUN steps); no backpressure: starts while busy are dropped, abort cancels.
module seq_mult_radix #(
    parameter int DW         = 8,
    parameter int R          = 2,
    parameter int EARLY_TERM = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_signed,
    input  logic [DW-1:0]   multiplicand,
    input  logic [DW-1:0]   multiplier,
    input  logic            abort,
    output logic            busy,
    output logic            valid,
    output logic [2*DW-1:0] product
);

    localparam int N  = (DW + R - 1) / R;
    localparam int MW = N * R;
    localparam int PW = 2 * DW;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Operation context captured at start: magnitudes and result sign.
    typedef struct packed {
        logic          sign;
        logic [PW-1:0] mcand;
        logic [MW-1:0] mplier;
    } op_t;

    state_t        state;
    state_t        state_nxt;
    op_t           op_q;
    logic [PW-1:0] acc;
    logic [CW-1:0] step_cnt;

    logic          accept;
    logic [R-1:0]  digit;
    logic [PW-1:0] pp;
    logic [PW-1:0] acc_nxt;
    logic [MW-1:0] mplier_nxt;
    logic          step_last;

    function automatic logic [DW-1:0] mag(input logic [DW-1:0] v, input logic sg);
        return (sg && v[DW-1]) ? (~v + DW'(1)) : v;
    endfunction

    assign busy       = (state != IDLE);
    assign accept     = (state == IDLE) && start && !abort;
    assign digit      = op_q.mplier[R-1:0];
    assign pp         = op_q.mcand * PW'(digit);
    assign acc_nxt    = acc + pp;
    assign mplier_nxt = op_q.mplier >> R;

    // Early exit looks at the multiplier left after this step, so a zero multiplier still takes one step.
    always_comb begin
        step_last = 1'b0;
        if (EARLY_TERM != 0) begin
            step_last = (mplier_nxt == '0);
        end else begin
            step_last = (step_cnt == CW'(N - 1));
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (step_last) begin
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= '0;
            acc      <= '0;
            step_cnt <= '0;
            product  <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (accept) begin
                op_q.sign   <= is_signed & (multiplicand[DW-1] ^ multiplier[DW-1]);
                op_q.mcand  <= PW'(mag(multiplicand, is_signed));
                op_q.mplier <= MW'(mag(multiplier, is_signed));
                acc         <= '0;
                step_cnt    <= '0;
            end else if (state == RUN && !abort) begin
                acc         <= acc_nxt;
                op_q.mcand  <= op_q.mcand << R;
                op_q.mplier <= mplier_nxt;
                step_cnt    <= step_cnt + CW'(1);
            end else if (state == FIN && !abort) begin
                product <= op_q.sign ? (~acc + PW'(1)) : acc;
                valid   <= 1'b1;
            end
        end
    end

    a_valid_idle: assert property (@(posedge clk) disable iff (!rst_n) valid |-> !busy);
    a_valid_pulse: assert property (@(posedge clk) disable iff (!rst_n) valid |=> !valid);

endmodule

// File: tb/tb_seq_mult_radix.sv
// Bench for seq_mult_radix: four instances (R=2/1/4 early-exit, R=2 fixed latency) against a cycle-level reference.
module tb_seq_mult_radix;

    localparam int NI = 4;

    logic        clk;
    logic        rst_n;
    logic        start_s     [NI];
    logic        is_signed_s [NI];
    logic        abort_s     [NI];
    logic [7:0]  a_s         [NI];
    logic [7:0]  b_s         [NI];
    logic        busy_s      [NI];
    logic        valid_s     [NI];
    logic [15:0] prod_s      [NI];

    int r_of  [NI] = '{2, 1, 4, 2};
    bit et_of [NI] = '{1'b1, 1'b1, 1'b1, 1'b0};

    int n_cmp;
    int n_bad;

    longint      cyc;
    bit          inflight [NI];
    longint      fin_edge [NI];
    logic [15:0] exp_p    [NI];
    logic [15:0] prod_m   [NI];
    bit          valid_m  [NI];
    int          k_m      [NI];
    int          done_cnt [NI];
    int          run_len  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        seq_mult_radix #(
            .DW(8),
            .R((g == 1) ? 1 : (g == 2) ? 4 : 2),
            .EARLY_TERM((g == 3) ? 0 : 1)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .start(start_s[g]),
            .is_signed(is_signed_s[g]),
            .multiplicand(a_s[g]),
            .multiplier(b_s[g]),
            .abort(abort_s[g]),
            .busy(busy_s[g]),
            .valid(valid_s[g]),
            .product(prod_s[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_prod(input bit sg, input logic [7:0] a, input logic [7:0] b);
        int x;
        int y;
        x = sg ? int'($signed(a)) : int'(a);
        y = sg ? int'($signed(b)) : int'(b);
        return 16'(x * y);
    endfunction

    // RUN steps: digits needed to cover the multiplier magnitude (at least one), or all digits when fixed.
    function automatic int ref_k(input int r, input bit et, input bit sg, input logic [7:0] b);
        int m;
        int nb;
        int k;
        m  = (sg && b[7]) ? 256 - int'(b) : int'(b);
        nb = 0;
        while (m > 0) begin
            nb++;
            m = m >> 1;
        end
        if (!et) return (8 + r - 1) / r;
        k = (nb + r - 1) / r;
        return (k < 1) ? 1 : k;
    endfunction

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'h01;
            2:       return 8'h7f;
            3:       return 8'h80;
            4:       return 8'hff;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        cyc++;
        for (int i = 0; i < NI; i++) begin
            valid_m[i] = 1'b0;
            if (!rst_n) begin
                inflight[i] = 1'b0;
                prod_m[i]   = 16'h0;
            end else if (inflight[i]) begin
                if (abort_s[i]) begin
                    inflight[i] = 1'b0;
                end else if (cyc == fin_edge[i]) begin
                    inflight[i] = 1'b0;
                    valid_m[i]  = 1'b1;
                    prod_m[i]   = exp_p[i];
                    done_cnt[i]++;
                end
            end else if (start_s[i] && !abort_s[i]) begin
                inflight[i] = 1'b1;
                k_m[i]      = ref_k(r_of[i], et_of[i], is_signed_s[i], b_s[i]);
                exp_p[i]    = ref_prod(is_signed_s[i], a_s[i], b_s[i]);
                fin_edge[i] = cyc + k_m[i] + 1;
            end
        end
    endtask

    task automatic cmp_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("busy%0d", i), 32'(busy_s[i]), 32'(inflight[i]));
            chk($sformatf("valid%0d", i), 32'(valid_s[i]), 32'(valid_m[i]));
            chk($sformatf("product%0d", i), 32'(prod_s[i]), 32'(prod_m[i]));
            if (busy_s[i]) begin
                run_len[i]++;
            end else begin
                if (valid_s[i] && valid_m[i]) chk($sformatf("runs%0d", i), 32'(run_len[i] - 1), 32'(k_m[i]));
                run_len[i] = 0;
            end
        end
    endtask

    // Drives one operation from the post-edge phase; returns product, edges to valid, and RUN steps seen on busy.
    task automatic op(input int i, input bit sg, input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] p, output int lat, output int k);
        int runs;
        is_signed_s[i] = sg;
        a_s[i]         = a;
        b_s[i]         = b;
        start_s[i]     = 1'b1;
        @(posedge clk); #1;
        start_s[i] = 1'b0;
        lat  = 0;
        runs = 0;
        while (!valid_s[i] && lat < 40) begin
            if (busy_s[i]) runs++;
            @(posedge clk); #1;
            lat++;
        end
        chk("op_valid_seen", 32'(valid_s[i]), 32'd1);
        p = prod_s[i];
        k = runs - 1;
    endtask

    task automatic rand_drive(input int i);
        int base;
        int cycles;
        base   = done_cnt[i];
        cycles = 0;
        while ((done_cnt[i] - base) < 1000 && cycles < 40000) begin
            @(posedge clk); #1;
            start_s[i]     = ($urandom_range(0, 1) == 0);
            is_signed_s[i] = 1'($urandom_range(0, 1));
            a_s[i]         = pick();
            b_s[i]         = pick();
            abort_s[i]     = ($urandom_range(0, 49) == 0);
            cycles++;
        end
        start_s[i] = 1'b0;
        abort_s[i] = 1'b0;
        chk($sformatf("sweep_done_r%0d", r_of[i]), 32'((done_cnt[i] - base) >= 1000), 32'd1);
    endtask

    initial begin
        logic [15:0] p;
        int          lat;
        int          k;
        bit          seen;

        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            start_s[i]     = 1'b0;
            is_signed_s[i] = 1'b0;
            abort_s[i]     = 1'b0;
            a_s[i]         = 8'h0;
            b_s[i]         = 8'h0;
            inflight[i]    = 1'b0;
            fin_edge[i]    = 0;
            exp_p[i]       = 16'h0;
            prod_m[i]      = 16'h0;
            valid_m[i]     = 1'b0;
            k_m[i]         = 0;
            done_cnt[i]    = 0;
            run_len[i]     = 0;
        end

        fork
            forever begin
                @(posedge clk);
                model_step();
            end
            begin
                @(posedge clk);
                forever begin
                    @(negedge clk);
                    cmp_all();
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_busy", 32'(busy_s[i]), 32'd0);
            chk("rst_valid", 32'(valid_s[i]), 32'd0);
            chk("rst_product", 32'(prod_s[i]), 32'd0);
        end
        rst_n = 1'b1;

        op(0, 1'b0, 8'd255, 8'd255, p, lat, k);
        chk("u255x255_p", 32'(p), 32'hFE01);
        chk("u255x255_lat", 32'(lat), 32'd5);
        chk("u255x255_k", 32'(k), 32'd4);

        op(0, 1'b1, 8'h80, 8'h80, p, lat, k);
        chk("sm128xm128_p", 32'(p), 32'h4000);
        chk("b2b_lat", 32'(lat), 32'd5);

        op(0, 1'b1, 8'hFD, 8'd5, p, lat, k);
        chk("sm3x5_p", 32'(p), 32'hFFF1);
        chk("sm3x5_lat", 32'(lat), 32'd3);
        chk("sm3x5_k", 32'(k), 32'd2);

        op(0, 1'b0, 8'd200, 8'd0, p, lat, k);
        chk("u200x0_p", 32'(p), 32'd0);
        chk("u200x0_lat", 32'(lat), 32'd2);
        chk("u200x0_k", 32'(k), 32'd1);

        op(0, 1'b0, 8'd200, 8'd1, p, lat, k);
        chk("u200x1_p", 32'(p), 32'd200);

        op(3, 1'b0, 8'd7, 8'd3, p, lat, k);
        chk("fixed7x3_p", 32'(p), 32'd21);
        chk("fixed7x3_k", 32'(k), 32'd4);
        chk("fixed7x3_lat", 32'(lat), 32'd5);

        // Second start lands two edges after acceptance and must be dropped.
        is_signed_s[0] = 1'b0;
        a_s[0]         = 8'd255;
        b_s[0]         = 8'd255;
        start_s[0]     = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        @(posedge clk); #1;
        a_s[0]     = 8'd3;
        b_s[0]     = 8'd3;
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        lat = 2;
        while (!valid_s[0] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ignored_start_lat", 32'(lat), 32'd5);
        chk("ignored_start_p", 32'(prod_s[0]), 32'hFE01);
        @(posedge clk); #1;
        chk("ignored_start_idle", 32'(busy_s[0]), 32'd0);

        // Abort sampled on the third edge after acceptance.
        a_s[0]     = 8'h12;
        b_s[0]     = 8'hFF;
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        abort_s[0] = 1'b1;
        @(posedge clk); #1;
        abort_s[0] = 1'b0;
        chk("abort_busy", 32'(busy_s[0]), 32'd0);
        seen = 1'b0;
        repeat (8) begin
            if (valid_s[0]) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        chk("abort_product", 32'(prod_s[0]), 32'hFE01);

        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        chk("abort_over_start", 32'(busy_s[0]), 32'd0);

        // Reset sampled two edges into an operation.
        a_s[0]     = 8'd255;
        b_s[0]     = 8'd255;
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++) begin
            chk("midrst_busy", 32'(busy_s[i]), 32'd0);
            chk("midrst_valid", 32'(valid_s[i]), 32'd0);
            chk("midrst_product", 32'(prod_s[i]), 32'd0);
        end
        rst_n = 1'b1;
        op(0, 1'b0, 8'd10, 8'd10, p, lat, k);
        chk("post_rst_p", 32'(p), 32'd100);
        chk("post_rst_lat", 32'(lat), 32'd3);

        fork
            rand_drive(0);
            rand_drive(1);
            rand_drive(2);
        join
        repeat (20) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
